// File: rtl/bram_fifo_ctrl.sv
// Streaming FIFO controller around a simple dual-address block RAM with a
// one-cycle registered read; a 2-entry output buffer hides the read latency.
module bram_fifo_ctrl #(
  parameter int memSize_p   = 8,
  parameter int dataWidth_p = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [dataWidth_p-1:0] in_data_i,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  output logic [dataWidth_p-1:0] out_data_o,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic                   mem_write_o,
  output logic                   mem_read_o,
  output logic [memSize_p-1:0]   mem_waddr_o,
  output logic [memSize_p-1:0]   mem_raddr_o,
  output logic [dataWidth_p-1:0] mem_wdata_o,
  input  logic [dataWidth_p-1:0] mem_rdata_i,
  output logic [memSize_p:0]     count_o,
  output logic                   full_o,
  output logic                   empty_o
);

  localparam logic [memSize_p:0] depth_c = {1'b1, {memSize_p{1'b0}}};
  localparam logic [memSize_p:0] zero_c  = {(memSize_p+1){1'b0}};
  localparam logic [memSize_p:0] one_c   = {{memSize_p{1'b0}}, 1'b1};

  logic [memSize_p:0]     wptr_r, rptr_r, count_s;
  logic [1:0]             occ_r, occ_next_s;
  logic                   inflight_r, valid_r;
  logic [dataWidth_p-1:0] head_r, tail_r;
  logic                   read_issue_s, write_s, pop_s, full_s, empty_s;

  assign count_s = wptr_r - rptr_r;
  assign full_s  = (count_s == depth_c);
  assign empty_s = (count_s == zero_c);

  // Reads win over writes because the RAM drops a read that coincides with a write.
  assign read_issue_s = !empty_s && (({1'b0, occ_r} + {2'b00, inflight_r}) < 3'd2);
  assign in_ready_o   = rst_ni && !full_s && !read_issue_s;
  assign write_s      = in_valid_i && in_ready_o;
  assign pop_s        = valid_r && out_ready_i;

  assign mem_read_o  = read_issue_s;
  assign mem_raddr_o = rptr_r[memSize_p-1:0];
  assign mem_write_o = write_s;
  assign mem_waddr_o = wptr_r[memSize_p-1:0];
  assign mem_wdata_o = in_data_i;
  assign count_o     = count_s;
  assign full_o      = full_s;
  assign empty_o     = empty_s;
  assign out_valid_o = valid_r;
  assign out_data_o  = head_r;

  // Next buffer occupancy from landing read data and consumer pops.
  always_comb begin
    occ_next_s = occ_r;
    case ({inflight_r, pop_s})
      2'b10:   occ_next_s = occ_r + 2'd1;
      2'b01:   occ_next_s = occ_r - 2'd1;
      default: occ_next_s = occ_r;
    endcase
  end

  // Pointers, in-flight flag and occupancy state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_r     <= zero_c;
      rptr_r     <= zero_c;
      inflight_r <= 1'b0;
      occ_r      <= 2'd0;
      valid_r    <= 1'b0;
    end else begin
      if (write_s) begin
        wptr_r <= wptr_r + one_c;
      end
      if (read_issue_s) begin
        rptr_r <= rptr_r + one_c;
      end
      inflight_r <= read_issue_s;
      occ_r      <= occ_next_s;
      valid_r    <= (occ_next_s != 2'd0);
    end
  end

  // Output buffer: head is presented downstream, tail queues behind it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_r <= {dataWidth_p{1'b0}};
      tail_r <= {dataWidth_p{1'b0}};
    end else if (inflight_r && pop_s) begin
      if (occ_r == 2'd2) begin
        head_r <= tail_r;
        tail_r <= mem_rdata_i;
      end else begin
        head_r <= mem_rdata_i;
      end
    end else if (inflight_r) begin
      if (occ_r == 2'd0) begin
        head_r <= mem_rdata_i;
      end else begin
        tail_r <= mem_rdata_i;
      end
    end else if (pop_s) begin
      head_r <= tail_r;
    end
  end

endmodule

// File: tb/tb_bram_fifo_ctrl.sv
// Randomized self-checking bench for bram_fifo_ctrl with a behavioural RAM
// and a queue-based reference model of FIFO contents and occupancy.
module tb_bram_fifo_ctrl;

  logic        clk = 1'b0, rst_n = 1'b1;
  logic [15:0] in_data = 16'h0, out_data, mem_wdata, mem_rdata = 16'h0;
  logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0;
  logic        mem_write, mem_read, full, empty;
  logic [2:0]  mem_waddr, mem_raddr;
  logic [3:0]  count;
  logic [15:0] ram [8];

  int tests = 0, fails = 0;

  bram_fifo_ctrl #(.memSize_p(3), .dataWidth_p(16)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .in_data_i(in_data), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .out_data_o(out_data), .out_valid_o(out_valid), .out_ready_i(out_ready),
    .mem_write_o(mem_write), .mem_read_o(mem_read),
    .mem_waddr_o(mem_waddr), .mem_raddr_o(mem_raddr),
    .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata),
    .count_o(count), .full_o(full), .empty_o(empty)
  );

  always #5 clk = ~clk;

  // RAM with one-cycle registered read
  always @(posedge clk) begin
    if (mem_write) ram[mem_waddr] <= mem_wdata;
    if (mem_read) mem_rdata <= ram[mem_raddr];
  end

  // reference model: words in RAM, buffer occupancy, in-flight read, FIFO contents
  int          m_cnt, m_occ, m_infl;
  logic [15:0] q[$];
  logic        e_issue, e_ready, e_vld;
  logic [3:0]  e_cnt;
  logic        o_rd, o_wr, o_rdy, o_vld, o_full, o_empty, have_pop, exp_bad;
  logic [15:0] o_data, exp_pop;
  logic [3:0]  o_cnt;
  logic [2:0]  o_waddr, o_raddr;

  task automatic model_clear();
    m_cnt = 0; m_occ = 0; m_infl = 0; q.delete();
  endtask

  task automatic apply_reset();
    @(posedge clk); #3;
    in_valid = 1'b0; out_ready = 1'b0; rst_n = 1'b0;
    model_clear();
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic drive(input logic v, input logic [15:0] d, input logic r);
    @(negedge clk);
    in_valid = v; in_data = d; out_ready = r;
    #1;
    e_issue = (m_cnt != 0) && (m_occ + m_infl < 2);
    e_ready = (m_cnt != 8) && !e_issue;
    e_vld   = (m_occ != 0);
    e_cnt   = 4'(m_cnt);
    o_rd = mem_read; o_wr = mem_write; o_rdy = in_ready; o_vld = out_valid;
    o_data = out_data; o_cnt = count; o_full = full; o_empty = empty;
    o_waddr = mem_waddr; o_raddr = mem_raddr;
    have_pop = 1'b0; exp_bad = 1'b0; exp_pop = 16'h0;
    if (v && o_rdy) q.push_back(d);
    if (o_vld && r) begin
      have_pop = 1'b1;
      if (q.size() > 0) exp_pop = q.pop_front();
      else exp_bad = 1'b1;
    end
    m_cnt  = m_cnt + ((v && e_ready) ? 1 : 0) - (e_issue ? 1 : 0);
    m_occ  = m_occ + m_infl - ((e_vld && r) ? 1 : 0);
    m_infl = e_issue ? 1 : 0;
    @(posedge clk);
  endtask

  task automatic test_reset();
    @(posedge clk); @(posedge clk); #3;
    in_valid = 1'b1; in_data = 16'h5555; rst_n = 1'b0;
    #1;
    tests++;
    if ({out_valid, out_data, count, empty, full, mem_read, mem_write} !== {1'b0, 16'h0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL reset_values got v=%b d=%h c=%0d e=%b f=%b rd=%b wr=%b, need 0 0000 0 1 0 0 0",
               out_valid, out_data, count, empty, full, mem_read, mem_write);
    end
    in_valid = 1'b0;
    model_clear();
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 16'h0, 1'b0);
      tests++;
      if ({o_rd, o_wr, o_vld, o_cnt} !== 7'b0) begin
        fails++;
        $display("FAIL idle_after_reset got rd=%b wr=%b v=%b c=%0d, need all 0", o_rd, o_wr, o_vld, o_cnt);
      end
    end
  endtask

  task automatic test_single_word();
    apply_reset();
    drive(1'b1, 16'hA5A5, 1'b0);
    tests++;
    if ({o_wr, o_rd, o_waddr} !== {1'b1, 1'b0, 3'd0}) begin
      fails++; $display("FAIL single_write got wr=%b rd=%b addr=%0d, need 1 0 0", o_wr, o_rd, o_waddr);
    end
    drive(1'b0, 16'h0, 1'b0);
    tests++;
    if ({o_rd, o_wr, o_raddr, o_cnt} !== {1'b1, 1'b0, 3'd0, 4'd1}) begin
      fails++; $display("FAIL single_read got rd=%b wr=%b addr=%0d c=%0d, need 1 0 0 1", o_rd, o_wr, o_raddr, o_cnt);
    end
    drive(1'b0, 16'h0, 1'b0);
    tests++;
    if (o_vld !== 1'b0) begin
      fails++; $display("FAIL single_early_valid got %b need 0", o_vld);
    end
    drive(1'b0, 16'h0, 1'b0);
    tests++;
    if ({o_vld, o_data, o_cnt, o_empty} !== {1'b1, 16'hA5A5, 4'd0, 1'b1}) begin
      fails++; $display("FAIL single_out got v=%b d=%h c=%0d e=%b, need 1 a5a5 0 1", o_vld, o_data, o_cnt, o_empty);
    end
    drive(1'b0, 16'h0, 1'b1);
    drive(1'b0, 16'h0, 1'b0);
    tests++;
    if (o_vld !== 1'b0) begin
      fails++; $display("FAIL single_popped got v=%b need 0", o_vld);
    end
  endtask

  task automatic test_fill();
    int nxt = 0, npop = 0;
    apply_reset();
    for (int i = 0; i < 14; i++) begin
      drive(1'b1, 16'(nxt), 1'b0);
      if (o_rdy) nxt++;
      tests++;
      if ({o_rdy, o_rd, o_vld, o_cnt} !== {e_ready, e_issue, e_vld, e_cnt}) begin
        fails++; $display("FAIL fill_cycle got rdy/rd/v/c=%b%b%b/%0d need %b%b%b/%0d",
                          o_rdy, o_rd, o_vld, o_cnt, e_ready, e_issue, e_vld, e_cnt);
      end
    end
    tests++;
    if ({nxt[7:0], o_rdy, o_full, o_cnt} !== {8'd10, 1'b0, 1'b1, 4'd8}) begin
      fails++; $display("FAIL fill_capacity got n=%0d rdy=%b full=%b c=%0d, need 10 0 1 8", nxt, o_rdy, o_full, o_cnt);
    end
    for (int i = 0; i < 40 && npop < 10; i++) begin
      drive(1'b0, 16'h0, 1'b1);
      if (have_pop) begin
        tests++;
        if (exp_bad || o_data !== 16'(npop)) begin
          fails++; $display("FAIL fill_drain got %h need %h", o_data, 16'(npop));
        end
        npop++;
      end
    end
    tests++;
    if (npop != 10) begin
      fails++; $display("FAIL fill_drain_count got %0d need 10", npop);
    end
  endtask

  task automatic test_wrap();
    int sent = 0, got = 0;
    logic v;
    apply_reset();
    for (int i = 0; i < 3000 && got < 24; i++) begin
      v = (sent < 24) ? 1'($urandom_range(0, 1)) : 1'b0;
      drive(v, 16'($urandom), 1'($urandom_range(0, 1)));
      if (v && o_rdy) sent++;
      if (have_pop) got++;
      tests++;
      if ({o_rdy, o_rd, o_vld, o_cnt} !== {e_ready, e_issue, e_vld, e_cnt} || o_cnt > 4'd8 ||
          o_full !== (o_cnt == 4'd8) || o_empty !== (o_cnt == 4'd0)) begin
        fails++; $display("FAIL wrap_cycle got rdy/rd/v/c/f/e=%b%b%b/%0d/%b%b need %b%b%b/%0d",
                          o_rdy, o_rd, o_vld, o_cnt, o_full, o_empty, e_ready, e_issue, e_vld, e_cnt);
      end
      if (have_pop) begin
        tests++;
        if (exp_bad || o_data !== exp_pop) begin
          fails++; $display("FAIL wrap_order got %h need %h", o_data, exp_pop);
        end
      end
    end
    tests++;
    if (got != 24) begin
      fails++; $display("FAIL wrap_total got %0d need 24", got);
    end
  endtask

  task automatic test_arbitration();
    logic hold = 1'b0, r;
    logic [15:0] held = 16'h0;
    apply_reset();
    for (int i = 0; i < 100; i++) begin
      r = (i < 60) ? ($urandom_range(0, 3) != 0) : 1'b1;
      drive(i < 60, 16'($urandom), r);
      tests++;
      if ((o_wr && o_rd) || {o_rdy, o_rd, o_vld, o_cnt} !== {e_ready, e_issue, e_vld, e_cnt} ||
          (hold && (!o_vld || o_data !== held))) begin
        fails++; $display("FAIL arb_cycle got wr/rd/rdy/v/c=%b%b%b%b/%0d d=%h need rd/rdy/v/c=%b%b%b/%0d held=%h",
                          o_wr, o_rd, o_rdy, o_vld, o_cnt, o_data, e_issue, e_ready, e_vld, e_cnt, held);
      end
      if (have_pop) begin
        tests++;
        if (exp_bad || o_data !== exp_pop) begin
          fails++; $display("FAIL arb_order got %h need %h", o_data, exp_pop);
        end
      end
      hold = o_vld && !r;
      held = o_data;
    end
    tests++;
    if (q.size() != 0) begin
      fails++; $display("FAIL arb_drain got %0d left need 0", q.size());
    end
  endtask

  task automatic test_reset_midstream();
    int acc = 0;
    logic seen = 1'b0;
    apply_reset();
    for (int i = 0; i < 30 && acc < 7; i++) begin
      drive(1'b1, 16'(16'h100 + acc), 1'b0);
      if (o_rdy) acc++;
    end
    drive(1'b0, 16'h0, 1'b1);
    drive(1'b0, 16'h0, 1'b0);
    tests++;
    if (o_rd !== 1'b1 || o_cnt !== 4'd5) begin
      fails++; $display("FAIL mid_setup got rd=%b c=%0d need 1 5", o_rd, o_cnt);
    end
    #3; rst_n = 1'b0; #1;
    model_clear();
    tests++;
    if ({out_valid, count} !== {1'b0, 4'd0}) begin
      fails++; $display("FAIL mid_reset got v=%b c=%0d need 0 0", out_valid, count);
    end
    @(negedge clk); rst_n = 1'b1;
    drive(1'b1, 16'h1234, 1'b1);
    for (int i = 0; i < 10 && !seen; i++) begin
      drive(1'b0, 16'h0, 1'b1);
      if (have_pop) begin
        seen = 1'b1;
        tests++;
        if (o_data !== 16'h1234) begin
          fails++; $display("FAIL mid_first_word got %h need 1234", o_data);
        end
      end
    end
    tests++;
    if (!seen) begin
      fails++; $display("FAIL mid_timeout got no output need 1234");
    end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_single_word();
    test_fill();
    test_wrap();
    test_arbitration();
    test_reset_midstream();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
